ucca_config: RTL and testbench
==============================

Name: ucca_config

Overview:
- Memory-mapped openMSP430 peripheral that supplies the UCC region bounds (ucc_min/ucc_max) to the UCCA region monitor.
- Latches and reports violations that the monitor signals back.
- Trusted software programs the bounds, then commits and locks them through a small FSM. Once locked, the bounds cannot change until reset.
- Violation PC, a violation counter and tamper flags are readable by software. Untrusted code cannot clear them.

Parameters:
- BASE_ADDR, 15'h0160: byte base address of the 6-word register window (0x0160–0x016B).
- DEC_WD, 3: width of word-offset decode.
- CNT_W, 8: width of the saturating violation counter.

Ports:
- clk  in  1  system clock
- system_reset_n  in  1  asynchronous active-low reset
- per_addr  in  14  peripheral word address
- per_din  in  16  write data
- per_en  in  1  peripheral access strobe
- per_we  in  2  byte write enables ({hi,lo}); 00 = read
- per_dout  out  16  read data; 0 when not selected
- pc  in  16  current program counter
- ucca_violation  in  1  reset request from the region monitor (level, may last several cycles)
- ucc_min  out  16  region lower bound to the monitor
- ucc_max  out  16  region upper bound to the monitor
- ucc_active  out  1  bounds committed and enforced
- tamper_reset  out  1  one-cycle pulse on an illegal config write while locked

Behaviour:
- Registers (word offset : name):
  - 0 MIN: R/W while unlocked.
  - 1 MAX: R/W while unlocked.
  - 2 CTRL: bit0 COMMIT, write-1 self-clearing, reads 0; bit1 LOCKED, read-only.
  - 3 STATUS:
    - bit0 VIOL: sticky, W1C.
    - bit1 TAMPER: sticky, W1C.
    - bit2 CFG_ERR: sticky, W1C.
    - bit3 CNT_SAT: read-only.
    - bits[15:8] = FSM state code.
  - 4 VIOL_PC: read-only.
  - 5 VIOL_CNT: read-only; CNT_W bits, zero-extended.
- Byte lanes are honoured for MIN and MAX. STATUS and CTRL act on the low byte only.
- Reads: per_dout is combinational. It is the selected register when per_en=1, per_we=00 and the address is in the window; otherwise 16'h0000.
- FSM states:
  - UNCONF (code 0): reset state.
    - ucc_min=16'hFFFF, ucc_max=16'h0000 (empty region), ucc_active=0.
    - Any write to MIN or MAX -> CONFIG.
  - CONFIG (code 1): MIN/MAX writable; outputs still the empty region.
    - COMMIT write with MIN<=MAX (unsigned) -> ACTIVE on the next edge.
    - COMMIT write with MIN>MAX: set CFG_ERR, stay in CONFIG.
  - ACTIVE (code 2): ucc_min/ucc_max = MIN/MAX from the edge after the COMMIT write. ucc_active=1. LOCKED=1.
    - Any write to MIN, MAX or CTRL is dropped. It sets TAMPER and pulses tamper_reset for exactly one cycle.
  - There is no exit from ACTIVE except system_reset_n.
- Violation capture:
  - Rising edge of ucca_violation (registered previous value) with VIOL=0: VIOL_PC <= pc and VIOL <= 1.
  - Rising edge with VIOL=1: VIOL_PC is held (first violation wins).
  - Every rising edge increments VIOL_CNT, saturating at all-ones. CNT_SAT=1 when saturated.
  - A violation that lasts multiple cycles counts once.
- W1C gating: STATUS W1C writes take effect only when ucc_active=0 or pc is outside [ucc_min, ucc_max] (inclusive compare). Otherwise the write is ignored and TAMPER is set. No tamper_reset pulse is issued in this case.
- Simultaneous events:
  - A rising violation edge and a W1C of VIOL in the same cycle: the set wins.
  - A COMMIT and a MIN/MAX write in the same cycle cannot occur (single word access per cycle).
- Reset:
  - system_reset_n low clears all state asynchronously: state=UNCONF, MIN=MAX=0, all flags, VIOL_PC and VIOL_CNT = 0, tamper_reset=0.
  - Reset mid-CONFIG discards the partially written bounds.
- Latency: register write visible on read the cycle after the write edge. ACTIVE outputs are valid 1 cycle after the COMMIT write.

Decomposition:
- Shared package `ucca_pkg`: register offsets, STATUS/CTRL bit indices, FSM state encodings (2-bit), and the reset-state empty-region constants.
- One sub-module, `ucca_viol_capture`: edge detect, first-PC latch and saturating counter. It is fed by set/clear strobes from the top-level FSM and decode.

Test Plan:
- Reset, then read 0x0164 and 0x0166 -> both 0. ucc_min=FFFF, ucc_max=0000, ucc_active=0.
- Write MIN=E000, MAX=E0FF, COMMIT -> next cycle ucc_active=1, ucc_min=E000, ucc_max=E0FF. CTRL reads 0002. STATUS[15:8]=02.
- In CONFIG, write MIN=E100, MAX=E000, COMMIT -> CFG_ERR=1, state stays 1, ucc_active=0.
- In ACTIVE, write MAX=FFFF -> MAX reads E0FF, TAMPER=1, tamper_reset high exactly one cycle.
- Violation pulses at pc=E010 (3 cycles wide), then pc=E020 -> VIOL_PC=E010, VIOL_CNT=2. W1C from pc=E050 is ignored and sets TAMPER. W1C from pc=C000 clears VIOL.
- Drive 300 violation edges -> VIOL_CNT=00FF, CNT_SAT=1. Assert system_reset_n=0 mid-sequence -> all registers 0 immediately.

Source files
------------

// File: rtl/ucca_pkg.sv
// Shared definitions for the UCCA configuration peripheral: register map,
// bit positions, FSM encoding and the empty-region constants.
package ucca_pkg;

    localparam logic [2:0] OFF_MIN      = 3'd0;
    localparam logic [2:0] OFF_MAX      = 3'd1;
    localparam logic [2:0] OFF_CTRL     = 3'd2;
    localparam logic [2:0] OFF_STATUS   = 3'd3;
    localparam logic [2:0] OFF_VIOL_PC  = 3'd4;
    localparam logic [2:0] OFF_VIOL_CNT = 3'd5;

    localparam int CTRL_COMMIT = 0;
    localparam int CTRL_LOCKED = 1;

    localparam int ST_VIOL    = 0;
    localparam int ST_TAMPER  = 1;
    localparam int ST_CFG_ERR = 2;
    localparam int ST_CNT_SAT = 3;

    typedef enum logic [1:0] {
        UNCONF = 2'd0,
        CONFIG = 2'd1,
        ACTIVE = 2'd2
    } cfg_state_e;

    // An inverted range (min > max) matches no address, so the monitor sees no region.
    localparam logic [15:0] EMPTY_MIN = 16'hFFFF;
    localparam logic [15:0] EMPTY_MAX = 16'h0000;

    function automatic logic [15:0] byte_merge(input logic [15:0] old_val,
                                               input logic [15:0] din,
                                               input logic [1:0]  we);
        return {we[1] ? din[15:8] : old_val[15:8],
                we[0] ? din[7:0]  : old_val[7:0]};
    endfunction

endpackage

// File: rtl/ucca_viol_capture.sv
// Violation bookkeeping: rising-edge detect, first-violation PC latch and a
// saturating edge counter.
module ucca_viol_capture #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             system_reset_n,
    input  logic             ucca_violation,
    input  logic             viol_clr,
    input  logic [15:0]      pc,
    output logic             viol,
    output logic [15:0]      viol_pc,
    output logic [CNT_W-1:0] viol_cnt,
    output logic             cnt_sat
);

    logic viol_prev;
    logic viol_rise;

    assign viol_rise = ucca_violation && !viol_prev;
    assign cnt_sat   = &viol_cnt;

    always_ff @(posedge clk or negedge system_reset_n) begin
        if (!system_reset_n) begin
            viol_prev <= 1'b0;
            viol      <= 1'b0;
            viol_pc   <= 16'h0000;
            viol_cnt  <= '0;
        end else begin
            // NOTE: non-blocking so every flop samples pre-edge values; viol below reads the old flag.
            viol_prev <= ucca_violation;
            if (viol_rise && !viol)
                viol_pc <= pc;
            // A new edge beats a simultaneous software clear.
            if (viol_rise)
                viol <= 1'b1;
            else if (viol_clr)
                viol <= 1'b0;
            if (viol_rise && !cnt_sat)
                viol_cnt <= viol_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/ucca_config.sv
// Memory-mapped UCCA bounds register block with commit/lock FSM, tamper
// detection and violation reporting for the openMSP430 peripheral bus.
module ucca_config
    import ucca_pkg::*;
#(
    parameter logic [14:0] BASE_ADDR = 15'h0160,
    parameter int          DEC_WD    = 3,
    parameter int          CNT_W     = 8
) (
    input  logic        clk,
    input  logic        system_reset_n,
    input  logic [13:0] per_addr,
    input  logic [15:0] per_din,
    input  logic        per_en,
    input  logic [1:0]  per_we,
    output logic [15:0] per_dout,
    input  logic [15:0] pc,
    input  logic        ucca_violation,
    output logic [15:0] ucc_min,
    output logic [15:0] ucc_max,
    output logic        ucc_active,
    output logic        tamper_reset
);

    cfg_state_e        state, state_nxt;
    logic [15:0]       min_r, max_r;
    logic              tamper, cfg_err;
    logic [DEC_WD-1:0] reg_off;
    logic              win_hit, reg_wr, reg_rd;
    logic              wr_min, wr_max, wr_ctrl, status_wr;
    logic              locked, illegal_wr, commit_req, bounds_ok, pc_inside;
    logic              w1c_ok, w1c_blocked;
    logic              viol, cnt_sat;
    logic [15:0]       viol_pc;
    logic [CNT_W-1:0]  viol_cnt;

    assign reg_off = per_addr[DEC_WD-1:0];
    assign win_hit = (per_addr[13:DEC_WD] == BASE_ADDR[14:DEC_WD+1]) && (reg_off <= OFF_VIOL_CNT);
    assign reg_wr  = per_en && (per_we != 2'b00) && win_hit;
    assign reg_rd  = per_en && (per_we == 2'b00) && win_hit;

    assign wr_min    = reg_wr && (reg_off == OFF_MIN);
    assign wr_max    = reg_wr && (reg_off == OFF_MAX);
    assign wr_ctrl   = reg_wr && (reg_off == OFF_CTRL);
    assign status_wr = reg_wr && (reg_off == OFF_STATUS) && per_we[0];

    assign locked     = (state == ACTIVE);
    assign ucc_active = locked;
    assign ucc_min    = locked ? min_r : EMPTY_MIN;
    assign ucc_max    = locked ? max_r : EMPTY_MAX;

    assign illegal_wr = locked && (wr_min || wr_max || wr_ctrl);
    assign commit_req = wr_ctrl && per_we[0] && per_din[CTRL_COMMIT];
    assign bounds_ok  = (min_r <= max_r);

    // Code running inside the protected region may not clear its own evidence.
    assign pc_inside   = (pc >= ucc_min) && (pc <= ucc_max);
    assign w1c_blocked = status_wr && ucc_active && pc_inside;
    assign w1c_ok      = status_wr && !w1c_blocked;

    always_comb begin
        // NOTE: default first so no branch leaves state_nxt unassigned (no latch).
        state_nxt = state;
        case (state)
            UNCONF:  if (wr_min || wr_max) state_nxt = CONFIG;
            CONFIG:  if (commit_req && bounds_ok) state_nxt = ACTIVE;
            ACTIVE:  state_nxt = ACTIVE;
            default: state_nxt = UNCONF;
        endcase
    end

    always_ff @(posedge clk or negedge system_reset_n) begin
        if (!system_reset_n) begin
            state        <= UNCONF;
            min_r        <= 16'h0000;
            max_r        <= 16'h0000;
            cfg_err      <= 1'b0;
            tamper       <= 1'b0;
            tamper_reset <= 1'b0;
        end else begin
            state        <= state_nxt;
            tamper_reset <= illegal_wr;
            if (wr_min && !locked)
                min_r <= byte_merge(min_r, per_din, per_we);
            if (wr_max && !locked)
                max_r <= byte_merge(max_r, per_din, per_we);
            if ((state == CONFIG) && commit_req && !bounds_ok)
                cfg_err <= 1'b1;
            else if (w1c_ok && per_din[ST_CFG_ERR])
                cfg_err <= 1'b0;
            if (illegal_wr || w1c_blocked)
                tamper <= 1'b1;
            else if (w1c_ok && per_din[ST_TAMPER])
                tamper <= 1'b0;
        end
    end

    ucca_viol_capture #(.CNT_W(CNT_W)) u_viol_capture (
        .clk            (clk),
        .system_reset_n (system_reset_n),
        .ucca_violation (ucca_violation),
        .viol_clr       (w1c_ok && per_din[ST_VIOL]),
        .pc             (pc),
        .viol           (viol),
        .viol_pc        (viol_pc),
        .viol_cnt       (viol_cnt),
        .cnt_sat        (cnt_sat)
    );

    always_comb begin
        per_dout = 16'h0000;
        if (reg_rd) begin
            case (reg_off)
                OFF_MIN:      per_dout = min_r;
                OFF_MAX:      per_dout = max_r;
                OFF_CTRL:     per_dout = {14'b0, locked, 1'b0};
                OFF_STATUS:   per_dout = {6'b0, state, 4'b0, cnt_sat, cfg_err, tamper, viol};
                OFF_VIOL_PC:  per_dout = viol_pc;
                OFF_VIOL_CNT: per_dout = {{(16-CNT_W){1'b0}}, viol_cnt};
                default:      per_dout = 16'h0000;
            endcase
        end
    end

endmodule

// File: tb/tb_ucca_config.sv
// Bench for ucca_config: directed scenarios with literal expectations, then
// randomized traffic compared every cycle against a behavioural model.
module tb_ucca_config;

    localparam logic [13:0] WBASE = 14'h00B0;

    logic        clk = 1'b0;
    logic        system_reset_n;
    logic [13:0] per_addr;
    logic [15:0] per_din;
    logic        per_en;
    logic [1:0]  per_we;
    logic [15:0] per_dout;
    logic [15:0] pc;
    logic        ucca_violation;
    logic [15:0] ucc_min, ucc_max;
    logic        ucc_active, tamper_reset;

    int n_tests = 0;
    int n_fail  = 0;
    bit cmp_on  = 1'b0;

    // Model state, in plain spec terms (state 0 unconfigured, 1 config, 2 active).
    logic [1:0]  m_state;
    logic [15:0] m_min, m_max, m_vpc;
    logic [7:0]  m_cnt;
    bit          m_viol, m_tamper, m_cfgerr, m_prev, m_tr;

    ucca_config dut (
        .clk            (clk),
        .system_reset_n (system_reset_n),
        .per_addr       (per_addr),
        .per_din        (per_din),
        .per_en         (per_en),
        .per_we         (per_we),
        .per_dout       (per_dout),
        .pc             (pc),
        .ucca_violation (ucca_violation),
        .ucc_min        (ucc_min),
        .ucc_max        (ucc_max),
        .ucc_active     (ucc_active),
        .tamper_reset   (tamper_reset)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state = 2'd0; m_min = 16'h0; m_max = 16'h0; m_vpc = 16'h0; m_cnt = 8'h0;
        m_viol = 0; m_tamper = 0; m_cfgerr = 0; m_prev = 0; m_tr = 0;
    endtask

    function automatic logic [15:0] model_read(input logic en, input logic [1:0] we, input logic [13:0] addr);
        int a = int'(addr);
        if (!en || we != 2'b00 || a < 'hB0 || a > 'hB5) return 16'h0000;
        case (a - 'hB0)
            0: return m_min;
            1: return m_max;
            2: return (m_state == 2'd2) ? 16'h0002 : 16'h0000;
            3: return {6'b0, m_state, 4'b0, (m_cnt == 8'hFF), m_cfgerr, m_tamper, m_viol};
            4: return m_vpc;
            default: return {8'h00, m_cnt};
        endcase
    endfunction

    // Applies one clock edge worth of spec rules to the model, using the inputs held across the edge.
    task automatic model_step();
        int a = int'(per_addr);
        int off = a - 'hB0;
        bit wr = per_en && (per_we != 2'b00) && (a >= 'hB0) && (a <= 'hB5);
        bit rise = ucca_violation && !m_prev;
        bit old_viol = m_viol;
        bit illegal = 0;
        logic [15:0] v;
        if (wr) begin
            if (off <= 2 && m_state == 2'd2) begin
                illegal = 1;
            end else if (off <= 1) begin
                v = (off == 0) ? m_min : m_max;
                if (per_we[0]) v[7:0]  = per_din[7:0];
                if (per_we[1]) v[15:8] = per_din[15:8];
                if (off == 0) m_min = v; else m_max = v;
                if (m_state == 2'd0) m_state = 2'd1;
            end else if (off == 2) begin
                if (per_we[0] && per_din[0] && m_state == 2'd1) begin
                    if (m_min <= m_max) m_state = 2'd2; else m_cfgerr = 1;
                end
            end else if (off == 3 && per_we[0]) begin
                if (m_state == 2'd2 && pc >= m_min && pc <= m_max) m_tamper = 1;
                else begin
                    if (per_din[0]) m_viol = 0;
                    if (per_din[1]) m_tamper = 0;
                    if (per_din[2]) m_cfgerr = 0;
                end
            end
        end
        if (illegal) m_tamper = 1;
        if (rise) begin
            if (!old_viol) m_vpc = pc;
            m_viol = 1;
            if (m_cnt != 8'hFF) m_cnt = m_cnt + 8'd1;
        end
        m_prev = ucca_violation;
        m_tr = illegal;
    endtask

    always @(negedge clk) begin
        if (cmp_on) begin
            check("ucc_min", ucc_min, (m_state == 2'd2) ? m_min : 16'hFFFF);
            check("ucc_max", ucc_max, (m_state == 2'd2) ? m_max : 16'h0000);
            check("ucc_active", {15'b0, ucc_active}, {15'b0, m_state == 2'd2});
            check("tamper_reset", {15'b0, tamper_reset}, {15'b0, m_tr});
            check("per_dout", per_dout, model_read(per_en, per_we, per_addr));
        end
    end

    task automatic drive(input bit en, input logic [1:0] we, input int off, input logic [15:0] din);
        per_en = en; per_we = we; per_addr = WBASE + 14'(off); per_din = din;
    endtask

    task automatic tick();
        @(posedge clk);
        if (system_reset_n) model_step();
        @(negedge clk);
        #1;
    endtask

    task automatic wr(input int off, input logic [1:0] we, input logic [15:0] din);
        drive(1, we, off, din);
        tick();
        drive(0, 2'b00, 0, 16'h0);
    endtask

    task automatic rd(input string name, input int off, input logic [15:0] exp);
        drive(1, 2'b00, off, 16'h0);
        #1;
        check(name, per_dout, exp);
        tick();
        drive(0, 2'b00, 0, 16'h0);
    endtask

    initial begin
        system_reset_n = 1'b0;
        pc = 16'h0000;
        ucca_violation = 1'b0;
        drive(0, 2'b00, 0, 16'h0);
        model_reset();
        repeat (3) @(negedge clk);
        #1;
        system_reset_n = 1'b1;
        cmp_on = 1'b1;

        rd("ctrl_after_reset", 2, 16'h0000);
        rd("status_after_reset", 3, 16'h0000);
        check("reset_min", ucc_min, 16'hFFFF);
        check("reset_max", ucc_max, 16'h0000);
        check("reset_active", {15'b0, ucc_active}, 16'h0000);

        // Inverted bounds must not commit.
        wr(0, 2'b11, 16'hE100);
        rd("status_config", 3, 16'h0100);
        wr(1, 2'b11, 16'hE000);
        wr(2, 2'b01, 16'h0001);
        rd("status_cfg_err", 3, 16'h0104);
        check("cfg_err_inactive", {15'b0, ucc_active}, 16'h0000);
        wr(3, 2'b01, 16'h0004);
        rd("status_cfg_err_clr", 3, 16'h0100);

        // Byte-lane writes build MIN=E000, MAX=E0FF.
        wr(0, 2'b11, 16'h1200);
        wr(0, 2'b10, 16'hE055);
        rd("min_byte_lane", 0, 16'hE000);
        wr(1, 2'b01, 16'h33FF);
        rd("max_byte_lane", 1, 16'hE0FF);

        wr(2, 2'b01, 16'h0001);
        check("commit_active", {15'b0, ucc_active}, 16'h0001);
        check("commit_min", ucc_min, 16'hE000);
        check("commit_max", ucc_max, 16'hE0FF);
        rd("ctrl_locked", 2, 16'h0002);
        rd("status_active", 3, 16'h0200);

        wr(1, 2'b11, 16'hFFFF);
        check("tamper_pulse_hi", {15'b0, tamper_reset}, 16'h0001);
        rd("max_locked", 1, 16'hE0FF);
        check("tamper_pulse_lo", {15'b0, tamper_reset}, 16'h0000);
        rd("status_tamper", 3, 16'h0202);

        pc = 16'hE010; ucca_violation = 1'b1;
        repeat (3) tick();
        ucca_violation = 1'b0;
        repeat (2) tick();
        pc = 16'hE020; ucca_violation = 1'b1;
        tick();
        ucca_violation = 1'b0;
        tick();
        rd("viol_pc_first", 4, 16'hE010);
        rd("viol_cnt_two", 5, 16'h0002);
        rd("status_viol", 3, 16'h0203);

        pc = 16'hC000;
        wr(3, 2'b01, 16'h0002);
        rd("tamper_clr_outside", 3, 16'h0201);
        pc = 16'hE050;
        wr(3, 2'b01, 16'h0001);
        rd("w1c_blocked_inside", 3, 16'h0203);
        check("w1c_no_pulse", {15'b0, tamper_reset}, 16'h0000);
        pc = 16'hC000;
        wr(3, 2'b01, 16'h0001);
        rd("w1c_viol_outside", 3, 16'h0202);

        repeat (300) begin
            ucca_violation = 1'b1; tick();
            ucca_violation = 1'b0; tick();
        end
        rd("viol_cnt_sat", 5, 16'h00FF);
        rd("status_cnt_sat", 3, 16'h020B);
        rd("viol_pc_after_clr", 4, 16'hC000);

        // Asynchronous reset in the middle of a violation pulse.
        ucca_violation = 1'b1;
        tick();
        #2;
        system_reset_n = 1'b0;
        model_reset();
        #1;
        check("async_rst_active", {15'b0, ucc_active}, 16'h0000);
        check("async_rst_min", ucc_min, 16'hFFFF);
        drive(1, 2'b00, 3, 16'h0); #1; check("async_rst_status", per_dout, 16'h0000);
        drive(1, 2'b00, 5, 16'h0); #1; check("async_rst_cnt", per_dout, 16'h0000);
        drive(1, 2'b00, 4, 16'h0); #1; check("async_rst_vpc", per_dout, 16'h0000);
        drive(1, 2'b00, 1, 16'h0); #1; check("async_rst_max", per_dout, 16'h0000);
        ucca_violation = 1'b0;
        drive(0, 2'b00, 0, 16'h0);
        @(negedge clk); #1;
        tick();
        system_reset_n = 1'b1;
        rd("min_after_reset", 0, 16'h0000);

        for (int i = 0; i < 4000; i++) begin
            int off;
            int pick;
            off = int'($urandom_range(0, 7));
            per_en = ($urandom_range(0, 3) != 0);
            per_we = 2'($urandom_range(0, 3));
            per_addr = ($urandom_range(0, 9) == 0) ? 14'($urandom) : WBASE + 14'(off);
            per_din = 16'($urandom);
            if (off == 2 && $urandom_range(0, 1) == 1) per_din[0] = 1'b1;
            pick = int'($urandom_range(0, 3));
            case (pick)
                0: pc = 16'($urandom);
                1: pc = m_min;
                2: pc = m_max;
                default: pc = 16'((32'(m_min) + 32'(m_max)) >> 1);
            endcase
            ucca_violation = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 399) == 0) begin
                system_reset_n = 1'b0;
                model_reset();
                tick();
                system_reset_n = 1'b1;
            end else begin
                tick();
            end
        end

        cmp_on = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
